stm32_bus_master: RTL and testbench

STM32_BUS_MASTER -- requirements
Module: stm32_bus_master

---
 rtl/stm32_bus_master_if.sv | 38 +++
 rtl/stm32_bus_master.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_stm32_bus_master.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stm32_bus_master_if.sv
// Request/result and bus-strobe bundle between a requester and stm32_bus_master.
// The shared DATA_BUS stays a plain inout port on the master.
interface stm32_bus_master_if;
  logic        start;
  logic [2:0]  op;
  logic        preamp;
  logic        tx_mode;
  logic [21:0] freq;
  logic [15:0] tx_i;
  logic [15:0] tx_q;
  logic [7:0]  test_pattern;
  logic        busy;
  logic        done;
  logic        error;
  logic        adc_otr;
  logic        dac_otr;
  logic [11:0] adc_min;
  logic [11:0] adc_max;
  logic [15:0] spec_i;
  logic [15:0] spec_q;
  logic [15:0] voice_i;
  logic [15:0] voice_q;
  logic        test_ok;
  logic        BUS_CLK;
  logic        DATA_SYNC;

  modport master (
    input  start, op, preamp, tx_mode, freq, tx_i, tx_q, test_pattern,
    output busy, done, error, adc_otr, dac_otr, adc_min, adc_max,
           spec_i, spec_q, voice_i, voice_q, test_ok, BUS_CLK, DATA_SYNC
  );

  modport slave (
    output start, op, preamp, tx_mode, freq, tx_i, tx_q, test_pattern,
    input  busy, done, error, adc_otr, dac_otr, adc_min, adc_max,
           spec_i, spec_q, voice_i, voice_q, test_ok, BUS_CLK, DATA_SYNC
  );
endinterface

// File: rtl/stm32_bus_master.sv
// Bus master for an STM32 responder: sends a command byte with DATA_SYNC, then
// N data edges of writes or reads on a shared 8-bit bus clocked by BUS_CLK.
// Optional feature macro: STM32_MASTER_BUSTEST_EN (op 0 write/echo bus test).
module stm32_bus_master #(
  parameter int unsigned HALF_PERIOD = 2
) (
  input  logic                clk_in,
  input  logic                rst_in,
  stm32_bus_master_if.master  bus,
  inout  wire  [7:0]          DATA_BUS
);

  localparam int unsigned PH_W   = 4;
  localparam int unsigned EDGE_W = 4;
  localparam int unsigned RBUF_W = 64;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF_PERIOD - 1);

`ifdef STM32_MASTER_BUSTEST_EN
  localparam bit BUSTEST = 1'b1;
`else
  localparam bit BUSTEST = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_CMD_LO, S_CMD_HI, S_DAT_LO, S_DAT_HI, S_DONE
  } state_e;

  // Number of data edges following the command edge.
  function automatic logic [EDGE_W-1:0] edge_count(input logic [2:0] op);
    case (op)
      3'd0:                edge_count = BUSTEST ? EDGE_W'(2) : EDGE_W'(0);
      3'd1, 3'd2, 3'd3:    edge_count = EDGE_W'(4);
      3'd4:                edge_count = EDGE_W'(8);
      default:             edge_count = EDGE_W'(0);
    endcase
  endfunction

  // True when data edge idx (0-based) is driven by the responder.
  function automatic logic is_read(input logic [2:0] op, input logic [EDGE_W-1:0] idx);
    case (op)
      3'd0:       is_read = BUSTEST && (idx == EDGE_W'(1));
      3'd2, 3'd4: is_read = 1'b1;
      default:    is_read = 1'b0;
    endcase
  endfunction

  // Byte the master drives on write edge idx (0-based).
  function automatic logic [7:0] wr_byte(input logic [2:0] op, input logic [EDGE_W-1:0] idx,
                                         input logic pre, input logic txm,
                                         input logic [21:0] fr, input logic [15:0] ti,
                                         input logic [15:0] tq, input logic [7:0] pat);
    wr_byte = 8'h00;
    case (op)
      3'd0: wr_byte = pat;
      3'd1: begin
        case (idx[1:0])
          2'd0:    wr_byte = {4'b0, txm, pre, 2'b0};
          2'd1:    wr_byte = {2'b0, fr[21:16]};
          2'd2:    wr_byte = fr[15:8];
          default: wr_byte = fr[7:0];
        endcase
      end
      3'd3: begin
        case (idx[1:0])
          2'd0:    wr_byte = tq[15:8];
          2'd1:    wr_byte = tq[7:0];
          2'd2:    wr_byte = ti[15:8];
          default: wr_byte = ti[7:0];
        endcase
      end
      default: wr_byte = 8'h00;
    endcase
  endfunction

  state_e              state_q, state_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [EDGE_W-1:0]   edge_q, edge_d;
  logic [2:0]          op_q, op_d;
  logic                preamp_q, preamp_d, tx_mode_q, tx_mode_d;
  logic [21:0]         freq_q, freq_d;
  logic [15:0]         tx_i_q, tx_i_d, tx_q_q, tx_q_d;
  logic [7:0]          pat_q, pat_d;
  logic [RBUF_W-1:0]   rbuf_q, rbuf_d;
  logic                busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic                bus_clk_q, bus_clk_d, sync_q, sync_d;
  logic                oe_q, oe_d;
  logic [7:0]          dout_q, dout_d;
  logic                adc_otr_q, adc_otr_d, dac_otr_q, dac_otr_d;
  logic [11:0]         adc_min_q, adc_min_d, adc_max_q, adc_max_d;
  logic [15:0]         spec_i_q, spec_i_d, spec_q_q, spec_q_d;
  logic [15:0]         voice_i_q, voice_i_d, voice_q_q, voice_q_d;
  logic                test_ok_q, test_ok_d;
  logic                phase_end;
  logic                op_err;

  assign phase_end = (phase_q == PH_LAST);
  assign op_err    = (bus.op == 3'd7) || (!BUSTEST && (bus.op == 3'd0));

  // Next-state, operand latching, read capture and registered-output decode.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    edge_d    = edge_q;
    op_d      = op_q;
    preamp_d  = preamp_q;
    tx_mode_d = tx_mode_q;
    freq_d    = freq_q;
    tx_i_d    = tx_i_q;
    tx_q_d    = tx_q_q;
    pat_d     = pat_q;
    rbuf_d    = rbuf_q;
    error_d   = 1'b0;
    adc_otr_d = adc_otr_q;
    dac_otr_d = dac_otr_q;
    adc_min_d = adc_min_q;
    adc_max_d = adc_max_q;
    spec_i_d  = spec_i_q;
    spec_q_d  = spec_q_q;
    voice_i_d = voice_i_q;
    voice_q_d = voice_q_q;
    test_ok_d = test_ok_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (op_err) begin
            error_d = 1'b1;
          end else begin
            op_d      = bus.op;
            preamp_d  = bus.preamp;
            tx_mode_d = bus.tx_mode;
            freq_d    = bus.freq;
            tx_i_d    = bus.tx_i;
            tx_q_d    = bus.tx_q;
            pat_d     = bus.test_pattern;
            rbuf_d    = '0;
            phase_d   = '0;
            edge_d    = '0;
            state_d   = S_CMD_LO;
          end
        end
      end
      S_CMD_LO: begin
        if (phase_end) begin
          phase_d = '0;
          state_d = S_CMD_HI;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_CMD_HI: begin
        if (phase_end) begin
          phase_d = '0;
          edge_d  = '0;
          state_d = (edge_count(op_q) == EDGE_W'(0)) ? S_DONE : S_DAT_LO;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_DAT_LO: begin
        if (phase_end) begin
          phase_d = '0;
          state_d = S_DAT_HI;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_DAT_HI: begin
        if (phase_end) begin
          phase_d = '0;
          if (is_read(op_q, edge_q)) begin
            rbuf_d = {rbuf_q[RBUF_W-9:0], DATA_BUS};
          end
          if (edge_q == edge_count(op_q) - EDGE_W'(1)) begin
            edge_d  = '0;
            state_d = S_DONE;
          end else begin
            edge_d  = edge_q + EDGE_W'(1);
            state_d = S_DAT_LO;
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    bus_clk_d = (state_d == S_CMD_HI) || (state_d == S_DAT_HI);
    sync_d    = (state_d == S_CMD_LO) || (state_d == S_CMD_HI);
    busy_d    = (state_d == S_CMD_LO) || (state_d == S_CMD_HI) ||
                (state_d == S_DAT_LO) || (state_d == S_DAT_HI);
    done_d    = (state_d == S_DONE);

    oe_d   = 1'b0;
    dout_d = 8'h00;
    if (sync_d) begin
      oe_d   = 1'b1;
      dout_d = {5'b0, op_d};
    end else if (((state_d == S_DAT_LO) || (state_d == S_DAT_HI)) && !is_read(op_d, edge_d)) begin
      oe_d   = 1'b1;
      dout_d = wr_byte(op_d, edge_d, preamp_d, tx_mode_d, freq_d, tx_i_d, tx_q_d, pat_d);
    end

    // Results become visible together in the DONE cycle.
    if (state_d == S_DONE) begin
      case (op_q)
        3'd0: test_ok_d = (rbuf_d[7:0] == pat_q);
        3'd2: begin
          adc_otr_d = rbuf_d[24];
          dac_otr_d = rbuf_d[25];
          adc_min_d = {rbuf_d[23:20], rbuf_d[15:8]};
          adc_max_d = {rbuf_d[19:16], rbuf_d[7:0]};
        end
        3'd4: begin
          spec_q_d  = rbuf_d[63:48];
          spec_i_d  = rbuf_d[47:32];
          voice_q_d = rbuf_d[31:16];
          voice_i_d = rbuf_d[15:0];
        end
        default: ;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      edge_q    <= '0;
      op_q      <= '0;
      preamp_q  <= 1'b0;
      tx_mode_q <= 1'b0;
      freq_q    <= '0;
      tx_i_q    <= '0;
      tx_q_q    <= '0;
      pat_q     <= '0;
      rbuf_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      bus_clk_q <= 1'b0;
      sync_q    <= 1'b0;
      oe_q      <= 1'b0;
      dout_q    <= '0;
      adc_otr_q <= 1'b0;
      dac_otr_q <= 1'b0;
      adc_min_q <= '0;
      adc_max_q <= '0;
      spec_i_q  <= '0;
      spec_q_q  <= '0;
      voice_i_q <= '0;
      voice_q_q <= '0;
      test_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      edge_q    <= edge_d;
      op_q      <= op_d;
      preamp_q  <= preamp_d;
      tx_mode_q <= tx_mode_d;
      freq_q    <= freq_d;
      tx_i_q    <= tx_i_d;
      tx_q_q    <= tx_q_d;
      pat_q     <= pat_d;
      rbuf_q    <= rbuf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      bus_clk_q <= bus_clk_d;
      sync_q    <= sync_d;
      oe_q      <= oe_d;
      dout_q    <= dout_d;
      adc_otr_q <= adc_otr_d;
      dac_otr_q <= dac_otr_d;
      adc_min_q <= adc_min_d;
      adc_max_q <= adc_max_d;
      spec_i_q  <= spec_i_d;
      spec_q_q  <= spec_q_d;
      voice_i_q <= voice_i_d;
      voice_q_q <= voice_q_d;
      test_ok_q <= test_ok_d;
    end
  end

  assign DATA_BUS      = oe_q ? dout_q : 8'hzz;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;
  assign bus.BUS_CLK   = bus_clk_q;
  assign bus.DATA_SYNC = sync_q;
  assign bus.adc_otr   = adc_otr_q;
  assign bus.dac_otr   = dac_otr_q;
  assign bus.adc_min   = adc_min_q;
  assign bus.adc_max   = adc_max_q;
  assign bus.spec_i    = spec_i_q;
  assign bus.spec_q    = spec_q_q;
  assign bus.voice_i   = voice_i_q;
  assign bus.voice_q   = voice_q_q;
`ifdef STM32_MASTER_BUSTEST_EN
  assign bus.test_ok   = test_ok_q;
`else
  assign bus.test_ok   = 1'b0;
`endif

endmodule

// File: tb/tb_stm32_bus_master.sv
// Scoreboard bench for stm32_bus_master: a transaction-level model predicts the
// bus edges and the completion/results; monitors compare as the DUT presents them.
module tb_stm32_bus_master;
  localparam int unsigned HP = 2;
`ifdef STM32_MASTER_BUSTEST_EN
  localparam bit BT = 1'b1;
`else
  localparam bit BT = 1'b0;
`endif

  typedef struct packed {
    logic        adc_otr;
    logic        dac_otr;
    logic [11:0] adc_min;
    logic [11:0] adc_max;
    logic [15:0] spec_i;
    logic [15:0] spec_q;
    logic [15:0] voice_i;
    logic [15:0] voice_q;
    logic        test_ok;
  } res_t;

  typedef struct { int unsigned cyc; bit err; res_t res; } exp_t;
  typedef struct { logic [7:0] b; logic sync; } edge_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  wire  [7:0]  data_bus;
  logic        resp_oe = 1'b0;
  logic [7:0]  resp_dat = 8'h00;
  logic [7:0]  resp_bytes [8];
  int          resp_first = 99;
  int          resp_last = 0;
  int          edge_seen = 0;

  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  exp_t        exp_q[$];
  edge_t       bus_q[$];
  res_t        cur_res;
  res_t        last_res;
  logic        prev_bclk = 1'b0;

  assign data_bus = resp_oe ? resp_dat : 8'hzz;

  stm32_bus_master_if ifc();

  stm32_bus_master #(.HALF_PERIOD(HP)) dut (
    .clk_in  (clk),
    .rst_in  (rst),
    .bus     (ifc.master),
    .DATA_BUS(data_bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic res_t dut_res();
    res_t r;
    r.adc_otr = ifc.adc_otr;
    r.dac_otr = ifc.dac_otr;
    r.adc_min = ifc.adc_min;
    r.adc_max = ifc.adc_max;
    r.spec_i  = ifc.spec_i;
    r.spec_q  = ifc.spec_q;
    r.voice_i = ifc.voice_i;
    r.voice_q = ifc.voice_q;
    r.test_ok = ifc.test_ok;
    return r;
  endfunction

  // Responder: after each BUS_CLK fall, drive the byte of the next read edge.
  always @(negedge ifc.BUS_CLK) begin
    edge_seen = edge_seen + 1;
    if (edge_seen >= resp_first && edge_seen <= resp_last) begin
      resp_dat = resp_bytes[edge_seen-1];
      resp_oe  = 1'b1;
    end else begin
      resp_oe  = 1'b0;
    end
  end

  // Monitors: bus edges on BUS_CLK rise, completions on done/error.
  always @(negedge clk) begin
    if (!rst) begin
      if (ifc.BUS_CLK && !prev_bclk) begin
        if (bus_q.size() == 0) begin
          bad++; total++;
          $display("FAIL unexpected_edge: got byte %h with no edge expected", data_bus);
        end else begin
          edge_t e;
          e = bus_q.pop_front();
          check("bus_byte", 128'(data_bus), 128'(e.b));
          check("data_sync", 128'(ifc.DATA_SYNC), 128'(e.sync));
          check("results_hold", 128'(dut_res()), 128'(last_res));
        end
      end
      if (ifc.done || ifc.error) begin
        if (exp_q.size() == 0) begin
          bad++; total++;
          $display("FAIL unexpected_end: got done=%0d error=%0d expected none", ifc.done, ifc.error);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("end_kind", 128'({ifc.done, ifc.error}), 128'(e.err ? 2'b01 : 2'b10));
          check("end_cycle", 128'(cyc), 128'(e.cyc));
          check("results", 128'(dut_res()), 128'(e.res));
          check("busy_at_end", 128'(ifc.busy), 128'(0));
          last_res = e.res;
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
        bad++; total++;
        $display("FAIL end_timeout: got no end by cycle %0d expected at %0d", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
    end
    prev_bclk = ifc.BUS_CLK;
  end

  // Issue one transaction and push its predicted edges and completion.
  task automatic issue(input logic [2:0] op, input logic pre, input logic txm,
                       input logic [21:0] fr, input logic [15:0] ti, input logic [15:0] tq,
                       input logic [7:0] pat, input logic [63:0] rb);
    int         n;
    int         first_rd;
    bit         err;
    res_t       r;
    logic [7:0] wb [8];
    logic [7:0] rbyte [8];
    edge_t      ed;
    exp_t       ex;
    @(negedge clk);
    ifc.op = op; ifc.preamp = pre; ifc.tx_mode = txm; ifc.freq = fr;
    ifc.tx_i = ti; ifc.tx_q = tq; ifc.test_pattern = pat;
    ifc.start = 1'b1;
    for (int k = 0; k < 8; k++) begin
      rbyte[k] = rb[63-8*k -: 8];
      wb[k] = 8'h00;
    end
    err = (op == 3'd7) || (op == 3'd0 && !BT);
    r = cur_res;
    n = 0;
    first_rd = 99;
    if (!err) begin
      case (op)
        3'd0: begin n = 2; wb[0] = pat; first_rd = 2; r.test_ok = (rbyte[1] == pat); end
        3'd1: begin
          n = 4;
          wb[0] = 8'(({4'b0, txm, pre, 2'b0}));
          wb[1] = 8'(fr >> 16);
          wb[2] = 8'(fr >> 8);
          wb[3] = 8'(fr);
        end
        3'd2: begin
          n = 4; first_rd = 1;
          r.adc_otr = rbyte[0][0];
          r.dac_otr = rbyte[0][1];
          r.adc_min = 12'(rbyte[1] >> 4) * 12'd256 + 12'(rbyte[2]);
          r.adc_max = 12'(rbyte[1] & 8'h0F) * 12'd256 + 12'(rbyte[3]);
        end
        3'd3: begin
          n = 4;
          wb[0] = 8'(tq >> 8); wb[1] = 8'(tq); wb[2] = 8'(ti >> 8); wb[3] = 8'(ti);
        end
        3'd4: begin
          n = 8; first_rd = 1;
          r.spec_q  = {rbyte[0], rbyte[1]};
          r.spec_i  = {rbyte[2], rbyte[3]};
          r.voice_q = {rbyte[4], rbyte[5]};
          r.voice_i = {rbyte[6], rbyte[7]};
        end
        default: n = 0;
      endcase
      ed.b = {5'b0, op}; ed.sync = 1'b1;
      bus_q.push_back(ed);
      for (int k = 1; k <= n; k++) begin
        ed.b = (k >= first_rd) ? rbyte[k-1] : wb[k-1];
        ed.sync = 1'b0;
        bus_q.push_back(ed);
      end
      ex.cyc = cyc + 1 + (n + 1) * 2 * HP;
      ex.err = 1'b0;
      ex.res = r;
      cur_res = r;
    end else begin
      ex.cyc = cyc + 1;
      ex.err = 1'b1;
      ex.res = cur_res;
    end
    exp_q.push_back(ex);
    resp_oe = 1'b0;
    edge_seen = 0;
    resp_first = first_rd;
    resp_last = n;
    resp_bytes = rbyte;
    @(negedge clk);
    ifc.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() > 0 || ifc.busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      bad++; total++;
      $display("FAIL idle_timeout: got busy after %0d cycles expected idle", n);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [63:0] rb;
    logic [7:0]  pat;
    logic [2:0]  op;
    ifc.start = 1'b0; ifc.op = '0; ifc.preamp = 1'b0; ifc.tx_mode = 1'b0;
    ifc.freq = '0; ifc.tx_i = '0; ifc.tx_q = '0; ifc.test_pattern = '0;
    cur_res = '0;
    last_res = '0;

    repeat (3) @(negedge clk);
    check("rst_busy", 128'(ifc.busy), 128'(0));
    check("rst_done_err", 128'({ifc.done, ifc.error}), 128'(0));
    check("rst_bus_clk_sync", 128'({ifc.BUS_CLK, ifc.DATA_SYNC}), 128'(0));
    check("rst_results", 128'(dut_res()), 128'(0));
    rst = 1'b0;

    issue(3'd1, 1'b1, 1'b0, 22'd620407, 16'h0, 16'h0, 8'h0, 64'h0);
    wait_idle();
    issue(3'd2, 1'b0, 1'b0, 22'd0, 16'h0, 16'h0, 8'h0, 64'h03A5_1234_0000_0000);
    wait_idle();
    issue(3'd4, 1'b0, 1'b0, 22'd0, 16'h0, 16'h0, 8'h0, 64'h1122_3344_5566_7788);
    wait_idle();

    // AUDIO OFF with starts during busy and during DONE, both ignored.
    issue(3'd6, 1'b0, 1'b0, 22'd0, 16'h0, 16'h0, 8'h0, 64'h0);
    @(negedge clk);
    check("busy_mid", 128'(ifc.busy), 128'(1));
    ifc.op = 3'd1; ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (2) @(negedge clk);
    ifc.op = 3'd3; ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (30) @(negedge clk);
    check("ignored_starts", 128'(exp_q.size() + bus_q.size()), 128'(0));

    // Reset during data edge 2 of TX IQ.
    issue(3'd3, 1'b0, 1'b0, 22'd0, 16'hBEEF, 16'hCAFE, 8'h0, 64'h0);
    repeat (9) @(negedge clk);
    check("busy_before_rst", 128'(ifc.busy), 128'(1));
    rst = 1'b1;
    exp_q.delete();
    bus_q.delete();
    cur_res = '0;
    last_res = '0;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_bus_clk", 128'(ifc.BUS_CLK), 128'(0));
    check("mid_rst_sync_busy", 128'({ifc.DATA_SYNC, ifc.busy, ifc.done}), 128'(0));
    check("mid_rst_results", 128'(dut_res()), 128'(0));
    repeat (10) @(negedge clk);
    issue(3'd7, 1'b0, 1'b0, 22'd0, 16'h0, 16'h0, 8'h0, 64'h0);
    wait_idle();

    // Bus test: matching echo, then a wrong echo (error pulses when compiled out).
    issue(3'd0, 1'b0, 1'b0, 22'd0, 16'h0, 16'h0, 8'h5A, 64'h005A_0000_0000_0000);
    wait_idle();
    issue(3'd0, 1'b0, 1'b0, 22'd0, 16'h0, 16'h0, 8'h5A, 64'h005B_0000_0000_0000);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      pat = 8'($urandom);
      rb = {32'($urandom), 32'($urandom)};
      if (op == 3'd0) rb[55:48] = ($urandom_range(0, 1) != 0) ? pat : (pat ^ 8'h01);
      issue(op, 1'($urandom), 1'($urandom), 22'($urandom), 16'($urandom), 16'($urandom), pat, rb);
      wait_idle();
    end

    wait_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
